ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage that consumes the ID/EX pipeline bundle each cycle and produces the registered EX/MEM bundle.
- Contains operand forwarding, ALU, branch/jump resolution and the PC redirect.
- The ID/EX register has no flush input, so this block squashes wrong-path instructions itself with a kill counter.
- Sits between reg_ID_EX and the MEM stage; redirect outputs feed the PC mux.

Parameters:
- KILL_DEPTH, 2, number of wrong-path instructions squashed after a taken redirect.
- XLEN, 32, datapath width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold EX/MEM outputs and kill counter
- ex_valid  in  1  ID/EX slot holds a real instruction
- ex_rdata1, ex_rdata2  in  32  register operands
- ex_rs1, ex_rs2  in  5  source indices, for forwarding
- ex_rd  in  5  destination register
- ex_imm  in  32  immediate
- ex_a_sel  in  1  0=rs1, 1=pc
- ex_b_sel  in  1  0=rs2, 1=imm
- ex_alu_op  in  2  00 add, 01 branch compare, 10 R-type, 11 I-type
- ex_branch_flag  in  2  00 none, 01 conditional, 10 JAL, 11 JALR
- ex_regwrite, ex_memwrite  in  1  control
- ex_memtoreg  in  2  00 alu, 01 mem, 10 pc+4
- ex_pc, ex_pc_plus_4  in  32  pc values
- ex_funct3  in  3  instruction funct3
- ex_funct7  in  7  instruction funct7
- fw_mem_regwrite  in  1  MEM-stage write enable
- fw_mem_rd  in  5  MEM-stage destination
- fw_mem_data  in  32  MEM-stage result
- fw_wb_regwrite  in  1  WB-stage write enable
- fw_wb_rd  in  5  WB-stage destination
- fw_wb_data  in  32  WB-stage result
- redirect_valid  out  1  taken branch/jump this cycle (combinational)
- redirect_pc  out  32  target PC (combinational)
- mem_valid  out  1  EX/MEM slot valid
- mem_alu_result  out  32  registered ALU result
- mem_wdata  out  32  forwarded rs2 value, store data
- mem_rd  out  5  registered destination
- mem_regwrite, mem_memwrite  out  1  registered control, forced 0 when not valid
- mem_memtoreg  out  2  registered control
- mem_pc_plus_4  out  32  registered pc+4
- mem_funct3  out  3  registered funct3, access size

Behaviour:
- Reset is async on rst_n low. All mem_* outputs are 0 and kill_cnt is 0. redirect_valid is 0 because live is forced 0 while in reset.
- live = ex_valid & (kill_cnt==0) & ~stall.
- Forwarding per operand: MEM match wins over WB match. A match requires regwrite=1, rd==rs and rs!=0. Otherwise the ID/EX operand is used.
- Operand A = ex_a_sel ? ex_pc : fwd_rs1. Operand B = ex_b_sel ? ex_imm : fwd_rs2.
- alu_op 00: A+B.
- alu_op 01: A-B.
- alu_op 10: decode by funct3, with funct7[5] selecting SUB/SRA.
- alu_op 11: decode by funct3; funct7[5] applies only for funct3=101 (SRAI).
- Shift amount is B[4:0]. SLT is signed; SLTU is unsigned. All sums wrap mod 2^32.
- Conditional branch (flag 01): compare the forwarded rs1/rs2 values by funct3: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111. Other funct3 values mean not taken.
- Branch target = ex_pc + ex_imm.
- JAL target = ex_pc + ex_imm. JALR target = (fwd_rs1 + ex_imm) & ~1.
- redirect_valid = live & taken. The redirect is combinational, in the same cycle as EX.
- Kill counter:
  - On redirect_valid, load kill_cnt = KILL_DEPTH.
  - Otherwise, when ~stall and kill_cnt!=0, decrement by 1 on each cycle in which ex_valid=1. Bubbles arriving do not consume kill slots.
  - A killed instruction never redirects and enters EX/MEM as invalid.
- EX/MEM register:
  - When ~stall: mem_valid <= ex_valid & kill_cnt==0, and the remaining fields are loaded.
  - mem_regwrite and mem_memwrite are ANDed with that valid.
  - When stall=1: all mem_* outputs hold their values.
- Simultaneous stall and taken branch: no redirect is issued. The instruction stays in EX and resolves in the first unstalled cycle.
- Reset mid-kill: the counter clears, and the next instruction is live.

Decomposition:
- Shared package: alu_op, branch_flag and memtoreg encodings; funct3 constants for branch and ALU; KILL_DEPTH default.
- One sub-module is natural: ex_alu, purely combinational (A, B, alu_op, funct3, funct7 -> result).
- Forwarding, branch compare, kill counter and the EX/MEM register live in ex_stage.

Test Plan:
- Reset: hold rst_n=0 with live ex_valid ADD inputs -> all mem_* are 0 and redirect_valid=0; release -> first valid instruction passes.
- R-type SUB: rdata1=10, rdata2=3, funct7=0x20 -> mem_alu_result=7 next edge. SRA: rdata1=0x80000000 with shift 4 -> 0xF8000000.
- Forwarding: rs1=5, fw_mem_rd=5 with data 0x11, fw_wb_rd=5 with data 0x22 -> MEM value 0x11 is used. With rs1=0 and rd=0 matches -> rdata1 is used.
- BEQ taken: pc=0x100, imm=0x20, equal operands -> redirect_pc=0x120 same cycle. The next two valid instructions produce mem_valid=0 and no redirect; the third passes.
- JALR: rs1=0x1003, imm=0 -> redirect_pc=0x1002, mem_pc_plus_4 latched, memtoreg=10.
- Stall during taken BNE -> no redirect and mem_* held; deassert stall -> redirect fires once, then kill 2.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage.
// Control field values as they arrive from decode.
package ex_stage_pkg;

  localparam int KILL_DEPTH_DEF = 2;
  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_BRC = 2'b01,
    ALU_R   = 2'b10,
    ALU_I   = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_COND = 2'b01,
    BR_JAL  = 2'b10,
    BR_JALR = 2'b11
  } br_flag_e;

  typedef enum logic [1:0] {
    MTR_ALU = 2'b00,
    MTR_MEM = 2'b01,
    MTR_PC4 = 2'b10
  } memtoreg_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

endpackage

// File: rtl/ex_alu.sv
// Combinational integer ALU for the execute stage.
// funct7[5] picks SUB/SRA; I-type honours it only on shifts.
module ex_alu
  import ex_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  output logic [XLEN-1:0] result
);

  logic            alt;
  logic [4:0]      shamt;
  logic            lt_s;
  logic            lt_u;
  logic [XLEN-1:0] dec;
  logic            unused_f7;

  assign unused_f7 = ^{funct7[6], funct7[4:0]};
  assign shamt = b[4:0];
  assign lt_s = $signed(a) < $signed(b);
  assign lt_u = a < b;
  assign alt = funct7[5]
             & ((alu_op == ALU_R) | (funct3 == F3_SR));

  always_comb begin
    dec = '0;
    unique case (funct3)
      F3_ADD:  dec = alt ? a - b : a + b;
      F3_SLL:  dec = a << shamt;
      F3_SLT:  dec = {{(XLEN-1){1'b0}}, lt_s};
      F3_SLTU: dec = {{(XLEN-1){1'b0}}, lt_u};
      F3_XOR:  dec = a ^ b;
      F3_SR: begin
        if (alt)
          dec = $unsigned($signed(a) >>> shamt);
        else
          dec = a >> shamt;
      end
      F3_OR:   dec = a | b;
      F3_AND:  dec = a & b;
      default: dec = '0;
    endcase
  end

  always_comb begin
    result = '0;
    unique case (alu_op)
      ALU_ADD: result = a + b;
      ALU_BRC: result = a - b;
      ALU_R:   result = dec;
      ALU_I:   result = dec;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding, ALU, branch resolve, redirect and EX/MEM register.
// Wrong-path slots behind a redirect are squashed here by a kill counter.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int KILL_DEPTH = KILL_DEPTH_DEF,
  parameter int XLEN       = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_rdata1,
  input  logic [XLEN-1:0] ex_rdata2,
  input  logic [4:0]      ex_rs1,
  input  logic [4:0]      ex_rs2,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            ex_a_sel,
  input  logic            ex_b_sel,
  input  logic [1:0]      ex_alu_op,
  input  logic [1:0]      ex_branch_flag,
  input  logic            ex_regwrite,
  input  logic            ex_memwrite,
  input  logic [1:0]      ex_memtoreg,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_pc_plus_4,
  input  logic [2:0]      ex_funct3,
  input  logic [6:0]      ex_funct7,
  input  logic            fw_mem_regwrite,
  input  logic [4:0]      fw_mem_rd,
  input  logic [XLEN-1:0] fw_mem_data,
  input  logic            fw_wb_regwrite,
  input  logic [4:0]      fw_wb_rd,
  input  logic [XLEN-1:0] fw_wb_data,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            mem_valid,
  output logic [XLEN-1:0] mem_alu_result,
  output logic [XLEN-1:0] mem_wdata,
  output logic [4:0]      mem_rd,
  output logic            mem_regwrite,
  output logic            mem_memwrite,
  output logic [1:0]      mem_memtoreg,
  output logic [XLEN-1:0] mem_pc_plus_4,
  output logic [2:0]      mem_funct3
);

  localparam int KW =
    (KILL_DEPTH < 1) ? 1 : $clog2(KILL_DEPTH + 1);

  logic [KW-1:0]   kill_cnt;
  logic            kill_zero;
  logic            live;
  logic            slot_ok;
  alu_op_e         op;
  br_flag_e        br;
  logic            mem_hit1, wb_hit1;
  logic            mem_hit2, wb_hit2;
  logic [XLEN-1:0] fwd1, fwd2;
  logic [XLEN-1:0] op_a, op_b;
  logic [XLEN-1:0] alu_y;
  logic            eq, lt_s, lt_u;
  logic            cond;
  logic            taken;

  assign op = alu_op_e'(ex_alu_op);
  assign br = br_flag_e'(ex_branch_flag);

  assign kill_zero = (kill_cnt == '0);
  assign slot_ok = ex_valid & kill_zero;
  // rst_n gates live so no redirect escapes while held in reset
  assign live = slot_ok & ~stall & rst_n;

  assign mem_hit1 = fw_mem_regwrite
                  & (fw_mem_rd == ex_rs1)
                  & (ex_rs1 != 5'd0);
  assign wb_hit1 = fw_wb_regwrite
                 & (fw_wb_rd == ex_rs1)
                 & (ex_rs1 != 5'd0);
  assign mem_hit2 = fw_mem_regwrite
                  & (fw_mem_rd == ex_rs2)
                  & (ex_rs2 != 5'd0);
  assign wb_hit2 = fw_wb_regwrite
                 & (fw_wb_rd == ex_rs2)
                 & (ex_rs2 != 5'd0);

  always_comb begin
    fwd1 = ex_rdata1;
    priority case (1'b1)
      mem_hit1: fwd1 = fw_mem_data;
      wb_hit1:  fwd1 = fw_wb_data;
      default:  fwd1 = ex_rdata1;
    endcase
  end

  always_comb begin
    fwd2 = ex_rdata2;
    priority case (1'b1)
      mem_hit2: fwd2 = fw_mem_data;
      wb_hit2:  fwd2 = fw_wb_data;
      default:  fwd2 = ex_rdata2;
    endcase
  end

  assign op_a = ex_a_sel ? ex_pc : fwd1;
  assign op_b = ex_b_sel ? ex_imm : fwd2;

  ex_alu #(
    .XLEN (XLEN)
  ) u_alu (
    .a      (op_a),
    .b      (op_b),
    .alu_op (op),
    .funct3 (ex_funct3),
    .funct7 (ex_funct7),
    .result (alu_y)
  );

  assign eq = (fwd1 == fwd2);
  assign lt_s = $signed(fwd1) < $signed(fwd2);
  assign lt_u = fwd1 < fwd2;

  always_comb begin
    cond = 1'b0;
    unique case (ex_funct3)
      F3_BEQ:  cond = eq;
      F3_BNE:  cond = ~eq;
      F3_BLT:  cond = lt_s;
      F3_BGE:  cond = ~lt_s;
      F3_BLTU: cond = lt_u;
      F3_BGEU: cond = ~lt_u;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    unique case (br)
      BR_NONE: taken = 1'b0;
      BR_COND: taken = cond;
      BR_JAL:  taken = 1'b1;
      BR_JALR: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign redirect_valid = live & taken;
  assign redirect_pc = (br == BR_JALR)
                     ? ((fwd1 + ex_imm) & ~{{(XLEN-1){1'b0}}, 1'b1})
                     : (ex_pc + ex_imm);

  // bubbles do not consume kill slots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kill_cnt <= '0;
    end else if (redirect_valid) begin
      kill_cnt <= KW'(KILL_DEPTH);
    end else if (!stall && !kill_zero && ex_valid) begin
      kill_cnt <= kill_cnt - KW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid      <= 1'b0;
      mem_alu_result <= '0;
      mem_wdata      <= '0;
      mem_rd         <= '0;
      mem_regwrite   <= 1'b0;
      mem_memwrite   <= 1'b0;
      mem_memtoreg   <= '0;
      mem_pc_plus_4  <= '0;
      mem_funct3     <= '0;
    end else if (!stall) begin
      mem_valid      <= slot_ok;
      mem_alu_result <= alu_y;
      mem_wdata      <= fwd2;
      mem_rd         <= ex_rd;
      mem_regwrite   <= ex_regwrite & slot_ok;
      mem_memwrite   <= ex_memwrite & slot_ok;
      mem_memtoreg   <= ex_memtoreg;
      mem_pc_plus_4  <= ex_pc_plus_4;
      mem_funct3     <= ex_funct3;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage with an expected-result queue.
// Redirects are checked in-cycle, EX/MEM one edge later.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_rdata1, ex_rdata2;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_imm;
  logic        ex_a_sel, ex_b_sel;
  logic [1:0]  ex_alu_op, ex_branch_flag;
  logic        ex_regwrite, ex_memwrite;
  logic [1:0]  ex_memtoreg;
  logic [31:0] ex_pc, ex_pc_plus_4;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic        fw_mem_regwrite;
  logic [4:0]  fw_mem_rd;
  logic [31:0] fw_mem_data;
  logic        fw_wb_regwrite;
  logic [4:0]  fw_wb_rd;
  logic [31:0] fw_wb_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_valid;
  logic [31:0] mem_alu_result, mem_wdata;
  logic [4:0]  mem_rd;
  logic        mem_regwrite, mem_memwrite;
  logic [1:0]  mem_memtoreg;
  logic [31:0] mem_pc_plus_4;
  logic [2:0]  mem_funct3;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        rw;
    logic        mw;
    logic [1:0]  mtr;
    logic [31:0] pc4;
    logic [2:0]  f3;
  } rec_t;

  rec_t sb[$];
  rec_t last;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .ex_valid        (ex_valid),
    .ex_rdata1       (ex_rdata1),
    .ex_rdata2       (ex_rdata2),
    .ex_rs1          (ex_rs1),
    .ex_rs2          (ex_rs2),
    .ex_rd           (ex_rd),
    .ex_imm          (ex_imm),
    .ex_a_sel        (ex_a_sel),
    .ex_b_sel        (ex_b_sel),
    .ex_alu_op       (ex_alu_op),
    .ex_branch_flag  (ex_branch_flag),
    .ex_regwrite     (ex_regwrite),
    .ex_memwrite     (ex_memwrite),
    .ex_memtoreg     (ex_memtoreg),
    .ex_pc           (ex_pc),
    .ex_pc_plus_4    (ex_pc_plus_4),
    .ex_funct3       (ex_funct3),
    .ex_funct7       (ex_funct7),
    .fw_mem_regwrite (fw_mem_regwrite),
    .fw_mem_rd       (fw_mem_rd),
    .fw_mem_data     (fw_mem_data),
    .fw_wb_regwrite  (fw_wb_regwrite),
    .fw_wb_rd        (fw_wb_rd),
    .fw_wb_data      (fw_wb_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .mem_valid       (mem_valid),
    .mem_alu_result  (mem_alu_result),
    .mem_wdata       (mem_wdata),
    .mem_rd          (mem_rd),
    .mem_regwrite    (mem_regwrite),
    .mem_memwrite    (mem_memwrite),
    .mem_memtoreg    (mem_memtoreg),
    .mem_pc_plus_4   (mem_pc_plus_4),
    .mem_funct3      (mem_funct3)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input rec_t e);
    chk({tag, ".valid"}, 32'(mem_valid), 32'(e.valid));
    if (e.valid) begin
      chk({tag, ".alu"}, mem_alu_result, e.alu);
      chk({tag, ".wdata"}, mem_wdata, e.wdata);
    end
    chk({tag, ".rd"}, 32'(mem_rd), 32'(e.rd));
    chk({tag, ".regwrite"}, 32'(mem_regwrite), 32'(e.rw));
    chk({tag, ".memwrite"}, 32'(mem_memwrite), 32'(e.mw));
    chk({tag, ".memtoreg"}, 32'(mem_memtoreg), 32'(e.mtr));
    chk({tag, ".pc4"}, mem_pc_plus_4, e.pc4);
    chk({tag, ".funct3"}, 32'(mem_funct3), 32'(e.f3));
  endtask

  task automatic defaults();
    stall = 0; ex_valid = 1;
    ex_rdata1 = 0; ex_rdata2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 5'd1;
    ex_imm = 0; ex_a_sel = 0; ex_b_sel = 0;
    ex_alu_op = 2'b00; ex_branch_flag = 2'b00;
    ex_regwrite = 1; ex_memwrite = 0; ex_memtoreg = 2'b00;
    ex_pc = 32'h0; ex_pc_plus_4 = 32'h4;
    ex_funct3 = 0; ex_funct7 = 0;
    fw_mem_regwrite = 0; fw_mem_rd = 0; fw_mem_data = 0;
    fw_wb_regwrite = 0; fw_wb_rd = 0; fw_wb_data = 0;
  endtask

  // called at posedge+1 with inputs already driven
  task automatic step(input string tag, input logic ev,
                      input logic [31:0] ealu, input logic [31:0] ewd,
                      input logic eredir, input logic [31:0] erpc);
    rec_t r;
    #2;
    chk({tag, ".redir"}, 32'(redirect_valid), 32'(eredir));
    if (eredir) chk({tag, ".rpc"}, redirect_pc, erpc);
    if (!stall) begin
      r.valid = ev; r.alu = ealu; r.wdata = ewd; r.rd = ex_rd;
      r.rw = ex_regwrite & ev; r.mw = ex_memwrite & ev;
      r.mtr = ex_memtoreg; r.pc4 = ex_pc_plus_4; r.f3 = ex_funct3;
      sb.push_back(r);
    end
    @(posedge clk); #1;
    if (!stall) begin
      tests_run++;
      assert (sb.size() != 0) else begin
        tests_failed++;
        $error("FAIL %s.queue observed=empty expected=entry", tag);
      end
      if (sb.size() != 0) begin
        r = sb.pop_front();
        chk_rec(tag, r);
        last = r;
      end
    end else begin
      chk_rec({tag, ".hold"}, last);
    end
  endtask

  function automatic rec_t zero_rec();
    rec_t z;
    z.valid = 0; z.alu = 0; z.wdata = 0; z.rd = 0; z.rw = 0;
    z.mw = 0; z.mtr = 0; z.pc4 = 0; z.f3 = 0;
    return z;
  endfunction

  initial begin
    defaults();
    rst_n = 0;
    ex_rdata1 = 5; ex_rdata2 = 6; ex_branch_flag = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.redir", 32'(redirect_valid), 32'd0);
    last = zero_rec();
    last.alu = 0;
    chk_rec("rst", last);
    chk("rst.alu", mem_alu_result, 32'h0);
    rst_n = 1;

    // first instruction after reset
    defaults(); ex_rdata1 = 5; ex_rdata2 = 6;
    step("add", 1, 32'd11, 32'd6, 0, 0);

    defaults(); ex_alu_op = 2'b10; ex_funct7 = 7'h20;
    ex_rdata1 = 10; ex_rdata2 = 3;
    step("sub", 1, 32'd7, 32'd3, 0, 0);

    defaults(); ex_alu_op = 2'b10; ex_funct3 = 3'b101;
    ex_funct7 = 7'h20; ex_rdata1 = 32'h8000_0000; ex_rdata2 = 4;
    step("sra", 1, 32'hF800_0000, 32'd4, 0, 0);

    defaults(); ex_alu_op = 2'b10; ex_funct3 = 3'b101;
    ex_rdata1 = 32'h8000_0000; ex_rdata2 = 4;
    step("srl", 1, 32'h0800_0000, 32'd4, 0, 0);

    defaults(); ex_alu_op = 2'b11; ex_funct3 = 3'b101;
    ex_funct7 = 7'h20; ex_b_sel = 1; ex_imm = 32'h404;
    ex_rdata1 = 32'h8000_0000; ex_rdata2 = 32'h77;
    step("srai", 1, 32'hF800_0000, 32'h77, 0, 0);

    defaults(); ex_alu_op = 2'b11; ex_funct7 = 7'h20;
    ex_b_sel = 1; ex_imm = 3; ex_rdata1 = 10;
    step("addi_f7", 1, 32'd13, 32'd0, 0, 0);

    defaults(); ex_alu_op = 2'b10; ex_funct3 = 3'b010;
    ex_rdata1 = 32'hFFFF_FFFF; ex_rdata2 = 1;
    step("slt", 1, 32'd1, 32'd1, 0, 0);

    defaults(); ex_alu_op = 2'b10; ex_funct3 = 3'b011;
    ex_rdata1 = 32'hFFFF_FFFF; ex_rdata2 = 1;
    step("sltu", 1, 32'd0, 32'd1, 0, 0);

    defaults(); ex_rdata1 = 32'hFFFF_FFFF; ex_rdata2 = 2;
    ex_memwrite = 1; ex_regwrite = 0; ex_funct3 = 3'b010;
    step("add_wrap", 1, 32'd1, 32'd2, 0, 0);

    // forwarding priority
    defaults(); ex_rs1 = 5; ex_rdata1 = 32'h99;
    fw_mem_regwrite = 1; fw_mem_rd = 5; fw_mem_data = 32'h11;
    fw_wb_regwrite = 1; fw_wb_rd = 5; fw_wb_data = 32'h22;
    step("fwd_mem", 1, 32'h11, 32'h0, 0, 0);

    fw_mem_regwrite = 0;
    step("fwd_wb", 1, 32'h22, 32'h0, 0, 0);

    defaults(); ex_rdata1 = 32'h99;
    fw_mem_regwrite = 1; fw_mem_data = 32'h11;
    fw_wb_regwrite = 1; fw_wb_data = 32'h22;
    step("fwd_x0", 1, 32'h99, 32'h0, 0, 0);

    defaults(); ex_rs2 = 7; ex_rdata2 = 32'h3; ex_rdata1 = 32'h100;
    fw_mem_regwrite = 1; fw_mem_rd = 7; fw_mem_data = 32'h55;
    ex_memwrite = 1;
    step("fwd_rs2", 1, 32'h155, 32'h55, 0, 0);

    // not-taken conditionals
    defaults(); ex_branch_flag = 2'b01; ex_alu_op = 2'b01;
    ex_funct3 = 3'b001; ex_rdata1 = 7; ex_rdata2 = 7; ex_regwrite = 0;
    step("bne_nt", 1, 32'd0, 32'd7, 0, 0);
    ex_funct3 = 3'b010;
    step("f3_010_nt", 1, 32'd0, 32'd7, 0, 0);
    ex_funct3 = 3'b110; ex_rdata1 = 32'hFFFF_FFFF; ex_rdata2 = 1;
    step("bltu_nt", 1, 32'hFFFF_FFFE, 32'd1, 0, 0);
    ex_funct3 = 3'b101;
    step("bge_nt", 1, 32'hFFFF_FFFE, 32'd1, 0, 0);

    // BEQ taken then kill two valid slots, bubble in between
    defaults(); ex_branch_flag = 2'b01; ex_alu_op = 2'b01;
    ex_regwrite = 0; ex_pc = 32'h100; ex_pc_plus_4 = 32'h104;
    ex_imm = 32'h20; ex_rdata1 = 32'h42; ex_rdata2 = 32'h42;
    step("beq", 1, 32'd0, 32'h42, 1, 32'h120);
    defaults(); ex_branch_flag = 2'b10; ex_memwrite = 1;
    step("kill1", 0, 0, 0, 0, 0);
    defaults(); ex_valid = 0;
    step("bubble", 0, 0, 0, 0, 0);
    defaults(); ex_branch_flag = 2'b10;
    step("kill2", 0, 0, 0, 0, 0);
    defaults(); ex_rdata1 = 1; ex_rdata2 = 2;
    step("post_kill", 1, 32'd3, 32'd2, 0, 0);

    // JALR with odd target
    defaults(); ex_branch_flag = 2'b11; ex_b_sel = 1;
    ex_rdata1 = 32'h1003; ex_memtoreg = 2'b10;
    ex_pc = 32'h200; ex_pc_plus_4 = 32'h204;
    step("jalr", 1, 32'h1003, 32'h0, 1, 32'h1002);
    defaults();
    step("jalr_k1", 0, 0, 0, 0, 0);
    step("jalr_k2", 0, 0, 0, 0, 0);

    // BNE taken under stall
    defaults(); ex_branch_flag = 2'b01; ex_alu_op = 2'b01;
    ex_funct3 = 3'b001; ex_rdata1 = 1; ex_rdata2 = 2; ex_regwrite = 0;
    ex_pc = 32'h300; ex_pc_plus_4 = 32'h304; ex_imm = 32'hFFFF_FFF8;
    stall = 1;
    step("bne_stall1", 1, 0, 0, 0, 0);
    step("bne_stall2", 1, 0, 0, 0, 0);
    stall = 0;
    step("bne", 1, 32'hFFFF_FFFF, 32'd2, 1, 32'h2F8);
    step("bne_k1", 0, 0, 0, 0, 0);
    stall = 1;
    step("kill_stall", 0, 0, 0, 0, 0);
    stall = 0;
    step("bne_k2", 0, 0, 0, 0, 0);
    defaults(); ex_rdata1 = 4; ex_rdata2 = 4;
    step("post_bne", 1, 32'd8, 32'd4, 0, 0);

    // reset while kill slots remain
    defaults(); ex_branch_flag = 2'b10; ex_pc = 32'h400; ex_imm = 32'h10;
    ex_rdata1 = 1; ex_rdata2 = 1;
    step("jal", 1, 32'd2, 32'd1, 1, 32'h410);
    rst_n = 0;
    #2;
    chk("rst2.redir", 32'(redirect_valid), 32'd0);
    @(posedge clk); #1;
    last = zero_rec();
    chk_rec("rst2", last);
    rst_n = 1;
    defaults(); ex_rdata1 = 9; ex_rdata2 = 1;
    step("post_rst", 1, 32'd10, 32'd1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
